sat_alu_arbiter: RTL
====================

# sat_alu_arbiter

Two-requester round-robin arbiter and sequencer for the shared 16-bit saturating add/subtract datapath. It captures operands from the granted requester and computes the saturated sum or difference. The result is held in a single-entry output register under valid/ready backpressure, and the block counts saturation events. It sits between the register-file read ports of two issue slots and the ALU result bus.

## Interface
Parameters:
- CNT_W, 8, width of the saturation-event counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- a_req  in  1  requester A has an operation pending; held until a_ack.
- a_p1  in  16  requester A operand 1 (two's complement).
- a_p2  in  16  requester A operand 2.
- a_sub  in  1  requester A op: 0 = P1+P2, 1 = P1−P2.
- a_ack  out  1  combinational; operands of A captured this cycle.
- b_req, b_p1, b_p2, b_sub, b_ack  same as A, for requester B.
- res_valid  out  1  output register holds a result.
- res_ready  in  1  consumer accepts result when res_valid & res_ready.
- res  out  16  saturated result.
- res_id  out  1  owner of res: 0 = A, 1 = B.
- res_pos_sat  out  1  result clamped to 16'h7FFF.
- res_neg_sat  out  1  result clamped to 16'h8000.
- sat_cnt  out  CNT_W  count of saturating results delivered, sticks at all-ones.
- sat_clr  in  1  clears sat_cnt, synchronous.

## Operation
- Arithmetic on the granted operands:
  - x = P2 ^ {16{sub}}; s = P1 + x + sub, truncated to 16 bits.
  - Positive overflow: s[15] & ~P1[15] & ~x[15]. Result is then 16'h7FFF and pos_sat = 1.
  - Negative overflow: ~s[15] & P1[15] & x[15]. Result is then 16'h8000 and neg_sat = 1.
  - The two overflow cases are mutually exclusive; the flags are never both set.
- The output slot is "open" when res_valid = 0, or when res_valid & res_ready (drain and refill in the same cycle).
- Grant is issued only while the slot is open.
  - Only one requester active: that requester wins.
  - Both active: the requester not named by last_grant wins.
- last_grant updates to the winner on every grant. Its reset value is 1 (B), so A wins the first tie.
- On grant:
  - The winner's ack = 1 that cycle.
  - The next edge loads res, res_id, the sat flags and res_valid = 1.
- Drain without a new grant: res_valid = 0 at the next edge. res, res_id and the flags hold their last values.
- sat_cnt increments on each transfer (res_valid & res_ready) where either sat flag = 1.
  - Stops at 2^CNT_W − 1.
  - sat_clr has priority over increment; sat_clr during a saturating transfer leaves sat_cnt = 0.
- Requesters must keep req and operands stable until ack. Dropping req before ack is legal; no operation is then issued.
- States:
  - EMPTY (res_valid = 0). Grant moves to FULL.
  - FULL (res_valid = 1).
    - Stays FULL while res_ready = 0.
    - res_ready with a grant stays FULL with new data.
    - res_ready without a grant moves to EMPTY.

## Timing
- Latency: grant/ack cycle N, result visible at cycle N+1.
- Throughput: one result per cycle while res_ready = 1 and requests are present.
- With both requesters continuously active and res_ready = 1, grants alternate A, B, A, B…
- a_ack and b_ack are combinational from req, res_valid, res_ready and last_grant. They are never both 1.
- While res_valid = 1 and res_ready = 0, no ack is issued and the output is frozen.
- Reset values: res_valid = 0, res = 16'h0000, res_id = 0, res_pos_sat = 0, res_neg_sat = 0, sat_cnt = 0, last_grant = 1.
  - a_ack = b_ack = 0 while rst = 1.
- Reset asserted mid-operation discards any held result and any operand captured that cycle.
  - No ack is given while rst = 1.
  - The first grant after reset follows the tie rule above (A wins a tie).

## Test plan
- A only, 16'h7FFF + 16'h0001, add → a_ack in cycle N; cycle N+1: res = 16'h7FFF, res_pos_sat = 1, res_id = 0. On drain, sat_cnt = 1.
- B only, 16'h8000 − 16'h0001 → res = 16'h8000, res_neg_sat = 1, res_id = 1. Also 16'h0005 − 16'h0007 → res = 16'hFFFE, no flags.
- A and B held high, res_ready = 1 for 6 cycles → acks A, B, A, B, A, B; res_id sequence 0, 1, 0, 1, 0, 1.
- res_ready = 0 for 3 cycles with both requesting → no acks, res stable. On res_ready = 1, one transfer plus a new grant in the same cycle.
- rst pulsed while res_valid = 1 and both requesting → next cycle res_valid = 0, all outputs at reset values. First post-reset tie is granted to A.
- CNT_W = 2: five saturating transfers → sat_cnt 1, 2, 3, 3, 3. sat_clr concurrent with a saturating transfer → sat_cnt = 0.

Source files
------------

// File: rtl/sat_alu_arbiter_if.sv
// Bundle of the two requester ports and the result/backpressure bus of sat_alu_arbiter.
// The master side (issue slots plus result consumer) drives requests and res_ready; the slave is the arbiter.
interface sat_alu_arbiter_if #(
    parameter int CNT_W = 8
);
    logic             a_req;
    logic [15:0]      a_p1;
    logic [15:0]      a_p2;
    logic             a_sub;
    logic             a_ack;

    logic             b_req;
    logic [15:0]      b_p1;
    logic [15:0]      b_p2;
    logic             b_sub;
    logic             b_ack;

    logic             res_valid;
    logic             res_ready;
    logic [15:0]      res;
    logic             res_id;
    logic             res_pos_sat;
    logic             res_neg_sat;
    logic [CNT_W-1:0] sat_cnt;
    logic             sat_clr;

    modport master (
        output a_req, a_p1, a_p2, a_sub,
        output b_req, b_p1, b_p2, b_sub,
        output res_ready, sat_clr,
        input  a_ack, b_ack,
        input  res_valid, res, res_id, res_pos_sat, res_neg_sat, sat_cnt
    );

    modport slave (
        input  a_req, a_p1, a_p2, a_sub,
        input  b_req, b_p1, b_p2, b_sub,
        input  res_ready, sat_clr,
        output a_ack, b_ack,
        output res_valid, res, res_id, res_pos_sat, res_neg_sat, sat_cnt
    );
endinterface

// File: rtl/sat_alu_arbiter.sv
// Round-robin arbiter for two issue slots sharing one 16-bit saturating add/sub datapath,
// with a single-entry valid/ready result register and a sticky saturation-event counter.
module sat_alu_arbiter #(
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    sat_alu_arbiter_if.slave  bus
);
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state;
    logic             last_grant;
    logic [15:0]      res_q;
    logic             res_id_q;
    logic             pos_q;
    logic             neg_q;
    logic [CNT_W-1:0] cnt_q;

    logic             res_valid;
    logic             slot_open;
    logic             grant_a;
    logic             grant_b;
    logic             grant;
    logic             transfer;

    logic [15:0]      p1;
    logic [15:0]      p2;
    logic             sub;
    logic [15:0]      x;
    logic [15:0]      s;
    logic [15:0]      sat_val;
    logic             pos_ovf;
    logic             neg_ovf;

    assign res_valid = (state == FULL);
    assign slot_open = ~res_valid | bus.res_ready;
    assign transfer  = res_valid & bus.res_ready;

    // On a tie the requester not named by last_grant wins; nothing is granted during reset.
    assign grant_a = ~rst & slot_open & bus.a_req & (~bus.b_req | last_grant);
    assign grant_b = ~rst & slot_open & bus.b_req & (~bus.a_req | ~last_grant);
    assign grant   = grant_a | grant_b;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        p1  = bus.a_p1;
        p2  = bus.a_p2;
        sub = bus.a_sub;
        if (grant_b) begin
            p1  = bus.b_p1;
            p2  = bus.b_p2;
            sub = bus.b_sub;
        end
        x       = p2 ^ {16{sub}};
        s       = p1 + x + {15'b0, sub};
        pos_ovf = s[15] & ~p1[15] & ~x[15];
        neg_ovf = ~s[15] & p1[15] & x[15];
        sat_val = s;
        if (pos_ovf) begin
            sat_val = 16'h7FFF;
        end else if (neg_ovf) begin
            sat_val = 16'h8000;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state      <= EMPTY;
            last_grant <= 1'b1;
            res_q      <= 16'h0000;
            res_id_q   <= 1'b0;
            pos_q      <= 1'b0;
            neg_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            case (state)
                EMPTY:   if (grant) state <= FULL;
                FULL:    if (bus.res_ready && !grant) state <= EMPTY;
                default: state <= EMPTY;
            endcase

            // Without a grant the payload holds, so a drained result stays readable.
            if (grant) begin
                last_grant <= grant_b;
                res_q      <= sat_val;
                res_id_q   <= grant_b;
                pos_q      <= pos_ovf;
                neg_q      <= neg_ovf;
            end

            if (bus.sat_clr) begin
                cnt_q <= '0;
            end else if (transfer && (pos_q || neg_q) && (cnt_q != '1)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign bus.a_ack       = grant_a;
    assign bus.b_ack       = grant_b;
    assign bus.res_valid   = res_valid;
    assign bus.res         = res_q;
    assign bus.res_id      = res_id_q;
    assign bus.res_pos_sat = pos_q;
    assign bus.res_neg_sat = neg_q;
    assign bus.sat_cnt     = cnt_q;
endmodule
